address_table_writer: RTL and testbench

//  Builds the literal->clause address translation table before solving starts.

---
 rtl/address_table_writer_pkg.sv | 24 ++
 rtl/address_table_writer_if.sv | 36 +++
 rtl/address_table_writer_occ_mask_gen.sv | 22 ++
 rtl/address_table_writer.sv | 131 +++++++++++++
 tb/tb_address_table_writer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/address_table_writer_pkg.sv
// ============================================================================
// Module      : address_table_writer_pkg
// Description : Shared sizing defaults, count width and FSM encodings for the
//               literal->clause address table writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package address_table_writer_pkg;

  localparam int ATW_MCPV_DEFAULT = 20;
  localparam int ATW_LAW_DEFAULT  = 11;
  localparam int ATW_NV_DEFAULT   = 32;
  localparam int ATW_CNT_W        = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/address_table_writer_if.sv
// ============================================================================
// Module      : address_table_writer_if
// Description : Count stream in / table write port out of the table writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface address_table_writer_if
  import address_table_writer_pkg::*;
#(
  parameter int LAW  = ATW_LAW_DEFAULT,
  parameter int MCPV = ATW_MCPV_DEFAULT
);
  logic                 start_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [LAW:0]         in_idx_i;
  logic [ATW_CNT_W-1:0] in_cnt_i;
  logic                 in_last_i;
  logic                 wr_en_o;
  logic [LAW:0]         wr_idx_o;
  logic [LAW-1:0]       wr_addr_o;
  logic [MCPV-1:0]      wr_mask_o;

  modport slave (
    input  start_i, in_valid_i, in_idx_i, in_cnt_i, in_last_i,
    output in_ready_o, wr_en_o, wr_idx_o, wr_addr_o, wr_mask_o
  );

  modport master (
    output start_i, in_valid_i, in_idx_i, in_cnt_i, in_last_i,
    input  in_ready_o, wr_en_o, wr_idx_o, wr_addr_o, wr_mask_o
  );
endinterface

`default_nettype wire

// File: rtl/address_table_writer_occ_mask_gen.sv
// ============================================================================
// Module      : occ_mask_gen
// Description : Occurrence count to thermometer occupancy mask ((1<<cnt)-1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module occ_mask_gen #(
  parameter int MCPV = 20,
  parameter int CW   = 5
) (
  input  logic [CW-1:0]   cnt_i,
  output logic [MCPV-1:0] mask_o
);

  for (genvar i = 0; i < MCPV; i++) begin : g_bit
    assign mask_o[i] = (cnt_i > CW'(i));
  end

endmodule

`default_nettype wire

// File: rtl/address_table_writer.sv
// ============================================================================
// Module      : address_table_writer
// Description : Prefix-sums per-literal clause counts into base addresses and
//               writes {base, mask} per literal. Optional ATW_CLEAR_EN zeroes
//               the whole table before loading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module address_table_writer
  import address_table_writer_pkg::*;
#(
  parameter int MAX_CLAUSES_PER_VARIABLE = ATW_MCPV_DEFAULT,
  parameter int LITERAL_ADDRESS_WIDTH    = ATW_LAW_DEFAULT,
  parameter int NV                       = ATW_NV_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  address_table_writer_if.slave          bus,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [LITERAL_ADDRESS_WIDTH:0] used_o
);

  localparam int LAW     = LITERAL_ADDRESS_WIDTH;
  localparam int MCPV    = MAX_CLAUSES_PER_VARIABLE;
  localparam int AT_SIZE = 2 * NV;
  localparam int IDX_W   = LAW + 1;
  localparam int SUM_W   = LAW + 2;

  localparam logic [SUM_W-1:0]     c_ADDR_SPAN = SUM_W'(1) << LAW;
  localparam logic [IDX_W-1:0]     c_AT_SIZE   = IDX_W'(AT_SIZE);
  localparam logic [ATW_CNT_W-1:0] c_MCPV      = ATW_CNT_W'(MCPV);

  logic [2:0]       r_state;
  logic [LAW:0]     r_base;
  logic [SUM_W-1:0] w_sum;
  logic [MCPV-1:0]  w_mask;
  logic             w_accept;
  logic             w_bad;
  logic [2:0]       w_start_state;
`ifdef ATW_CLEAR_EN
  logic [IDX_W-1:0] r_clr_idx;
  assign w_start_state = ST_CLEAR;
`else
  assign w_start_state = ST_LOAD;
`endif

  occ_mask_gen #(
    .MCPV (MCPV),
    .CW   (ATW_CNT_W)
  ) u_occ_mask_gen (
    .cnt_i  (bus.in_cnt_i),
    .mask_o (w_mask)
  );

  assign bus.in_ready_o = (r_state == ST_LOAD);
  assign busy_o         = (r_state == ST_LOAD) || (r_state == ST_CLEAR);
  assign used_o         = r_base;
  assign w_accept       = bus.in_valid_i && (r_state == ST_LOAD);
  assign w_sum          = {1'b0, r_base} + SUM_W'(bus.in_cnt_i);
  // Landing exactly on the end of clause memory is legal; past it is not.
  assign w_bad          = (bus.in_cnt_i > c_MCPV) || (bus.in_idx_i >= c_AT_SIZE) ||
                          (w_sum > c_ADDR_SPAN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_base        <= '0;
      err_o         <= 1'b0;
      done_o        <= 1'b0;
      bus.wr_en_o   <= 1'b0;
      bus.wr_idx_o  <= '0;
      bus.wr_addr_o <= '0;
      bus.wr_mask_o <= '0;
`ifdef ATW_CLEAR_EN
      r_clr_idx     <= '0;
`endif
    end else begin
      bus.wr_en_o <= 1'b0;
      done_o      <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start_i) begin
            r_state <= w_start_state;
            r_base  <= '0;
            err_o   <= 1'b0;
`ifdef ATW_CLEAR_EN
            r_clr_idx <= '0;
`endif
          end
        end
`ifdef ATW_CLEAR_EN
        ST_CLEAR: begin
          bus.wr_en_o   <= 1'b1;
          bus.wr_idx_o  <= r_clr_idx;
          bus.wr_addr_o <= '0;
          bus.wr_mask_o <= '0;
          r_clr_idx     <= r_clr_idx + 1'b1;
          if (r_clr_idx == c_AT_SIZE - 1'b1) begin
            r_state <= ST_LOAD;
          end
        end
`endif
        ST_LOAD: begin
          if (w_accept) begin
            if (w_bad) begin
              r_state <= ST_ERR;
              err_o   <= 1'b1;
            end else begin
              bus.wr_en_o   <= 1'b1;
              bus.wr_idx_o  <= bus.in_idx_i;
              bus.wr_addr_o <= r_base[LAW-1:0];
              bus.wr_mask_o <= w_mask;
              r_base        <= w_sum[LAW:0];
              if (bus.in_last_i) begin
                r_state <= ST_DONE;
                done_o  <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_address_table_writer.sv
// ============================================================================
// Module      : tb_address_table_writer
// Description : Directed self-checking bench for address_table_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_address_table_writer;
  import address_table_writer_pkg::*;

  logic        clk;
  logic        reset;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] used;

  int total  = 0;
  int passed = 0;

  address_table_writer_if #(.LAW(11), .MCPV(20)) bus ();

  address_table_writer #(
    .MAX_CLAUSES_PER_VARIABLE (20),
    .LITERAL_ADDRESS_WIDTH    (11),
    .NV                       (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err),
    .used_o (used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("start_err_clr", err, 0);
    check("start_used_clr", used, 0);
    check("start_busy", busy, 1);
`ifdef ATW_CLEAR_EN
    for (int i = 0; i < 64; i++) begin
      check("clr_ready", bus.in_ready_o, 0);
      tick();
      check("clr_wr_en", bus.wr_en_o, 1);
      check("clr_wr_idx", bus.wr_idx_o, i);
      check("clr_wr_addr", bus.wr_addr_o, 0);
      check("clr_wr_mask", bus.wr_mask_o, 0);
    end
`endif
    check("start_ready", bus.in_ready_o, 1);
  endtask

  // One beat presented for one cycle; the expected result is hand-supplied.
  task automatic send(input int idx, input int cnt, input bit last, input bit exp_wr,
                      input int exp_addr, input int exp_mask, input bit exp_done);
    bus.in_valid_i = 1'b1;
    bus.in_idx_i   = 12'(idx);
    bus.in_cnt_i   = 5'(cnt);
    bus.in_last_i  = last;
    tick();
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    check("wr_en", bus.wr_en_o, exp_wr);
    if (exp_wr) begin
      check("wr_idx", bus.wr_idx_o, idx);
      check("wr_addr", bus.wr_addr_o, exp_addr);
      check("wr_mask", bus.wr_mask_o, exp_mask);
    end
    check("done", done, exp_done);
  endtask

  int t2_cnt[3]  = '{3, 0, 20};
  int t2_addr[3] = '{0, 3, 3};
  int t2_mask[3] = '{32'h7, 32'h0, 32'hFFFFF};

  initial begin
    int k;
    bit v;
    reset          = 1'b1;
    bus.start_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_idx_i   = '0;
    bus.in_cnt_i   = '0;
    bus.in_last_i  = 1'b0;
    tick();
    tick();
    check("rst_wr_en", bus.wr_en_o, 0);
    check("rst_ready", bus.in_ready_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_used", used, 0);
    reset = 1'b0;
    tick();
    check("idle_ready", bus.in_ready_o, 0);

    // 1: basic build, with a start pulse mid-load that must be ignored
    do_start();
    send(0, 3, 0, 1, 0, 32'h7, 0);
    check("t1_used_a", used, 3);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("t1_start_ignored", used, 3);
    check("t1_idle_no_wr", bus.wr_en_o, 0);
    send(1, 0, 0, 1, 3, 32'h0, 0);
    send(2, 20, 1, 1, 3, 32'hFFFFF, 1);
    check("t1_used", used, 23);
    check("t1_busy_done", busy, 0);
    check("t1_ready_done", bus.in_ready_o, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_no_extra_wr", bus.wr_en_o, 0);

    // 2: gaps in valid must neither drop nor duplicate writes
    do_start();
    k = 0;
    for (int c = 0; c < 100 && k < 3; c++) begin
      v = 1'($urandom_range(0, 1));
      bus.in_valid_i = v;
      bus.in_idx_i   = 12'(k);
      bus.in_cnt_i   = 5'(t2_cnt[k]);
      bus.in_last_i  = (k == 2);
      tick();
      check("t2_wr_en", bus.wr_en_o, v);
      if (v) begin
        check("t2_wr_idx", bus.wr_idx_o, k);
        check("t2_wr_addr", bus.wr_addr_o, t2_addr[k]);
        check("t2_wr_mask", bus.wr_mask_o, t2_mask[k]);
        check("t2_done", done, (k == 2));
        k++;
      end
    end
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    check("t2_all_beats", k, 3);
    check("t2_used", used, 23);

    // 3: count above maximum
    do_start();
    send(5, 21, 0, 0, 0, 0, 0);
    check("t3_err", err, 1);
    check("t3_ready", bus.in_ready_o, 0);
    check("t3_used", used, 0);
    tick();
    check("t3_err_sticky", err, 1);
    do_start();

    // index outside the table
    send(64, 1, 0, 0, 0, 0, 0);
    check("t3_idx_err", err, 1);

    // 4: fill to 2040, land exactly on 2048, then overflow by one
    do_start();
    for (int i = 0; i < 102; i++) begin
      send(i % 64, 20, 0, 1, 20 * i, 32'hFFFFF, 0);
    end
    check("t4_used_2040", used, 2040);
    send(7, 8, 0, 1, 2040, 32'hFF, 0);
    check("t4_used_2048", used, 2048);
    check("t4_no_err", err, 0);
    send(8, 1, 0, 0, 0, 0, 0);
    check("t4_ovf_err", err, 1);
    check("t4_used_hold", used, 2048);

    // 5: reset mid-load
    do_start();
    send(0, 5, 0, 1, 0, 32'h1F, 0);
    send(1, 6, 0, 1, 5, 32'h3F, 0);
    bus.in_valid_i = 1'b1;
    reset = 1'b1;
    #1;
    check("t5_wr_en", bus.wr_en_o, 0);
    check("t5_used", used, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", bus.in_ready_o, 0);
    check("t5_addr", bus.wr_addr_o, 0);
    tick();
    check("t5_hold_wr_en", bus.wr_en_o, 0);
    bus.in_valid_i = 1'b0;
    reset = 1'b0;
    tick();
    check("t5_idle", bus.in_ready_o, 0);
    do_start();
    send(3, 4, 1, 1, 0, 32'hF, 1);
    check("t5_used_new", used, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
